// File: rtl/led_scan_sequencer.sv
// LED panel row scanner: shifts one row of pixels, blanks, latches, moves the
// row address, unblanks and waits for the display delay before the next row.
module led_scan_sequencer #(
    parameter int COLS     = 64,
    parameter int ROW_BITS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     pix_valid,
    input  logic                     delay_done,
    output logic [$clog2(COLS)-1:0]  col_addr,
    output logic [ROW_BITS-1:0]      load_row,
    output logic [ROW_BITS-1:0]      row_addr,
    output logic                     sclk,
    output logic                     pix_shift,
    output logic                     delay_start,
    output logic                     latch_set,
    output logic                     latch_clr,
    output logic                     oe_enable,
    output logic                     oe_disable,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int CW = $clog2(COLS);

    typedef enum logic [3:0] {
        IDLE, SHIFT_LO, SHIFT_HI, BLANK, LATCH_ON,
        LATCH_OFF, ADDR, UNBLANK, WAIT, STOP
    } state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         col_nxt;
    logic [ROW_BITS-1:0]   load_nxt;
    logic [ROW_BITS-1:0]   row_nxt;
    logic                  last_col;
    logic                  last_row;

    assign last_col = (col_addr == CW'(COLS - 1));
    assign last_row = (load_row == {ROW_BITS{1'b1}});

    always_comb begin
        state_nxt = state;
        col_nxt   = col_addr;
        load_nxt  = load_row;
        row_nxt   = row_addr;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = SHIFT_LO;
                    col_nxt   = '0;
                end
            end
            SHIFT_LO: begin
                if (pix_valid) state_nxt = SHIFT_HI;
            end
            SHIFT_HI: begin
                if (last_col) begin
                    col_nxt   = '0;
                    state_nxt = BLANK;
                end else begin
                    col_nxt   = col_addr + CW'(1);
                    state_nxt = SHIFT_LO;
                end
            end
            BLANK:     state_nxt = LATCH_ON;
            LATCH_ON:  state_nxt = LATCH_OFF;
            LATCH_OFF: state_nxt = ADDR;
            ADDR: begin
                row_nxt   = load_row;
                state_nxt = UNBLANK;
            end
            UNBLANK:   state_nxt = WAIT;
            WAIT: begin
                // enable is only looked at here and in IDLE, so a row always finishes
                if (delay_done) begin
                    load_nxt  = load_row + ROW_BITS'(1);
                    state_nxt = enable ? SHIFT_LO : STOP;
                end
            end
            STOP:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Pulse outputs are decoded from the next state so they are flops aligned with their state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            col_addr    <= '0;
            load_row    <= '0;
            row_addr    <= '0;
            sclk        <= 1'b0;
            delay_start <= 1'b0;
            latch_set   <= 1'b0;
            latch_clr   <= 1'b0;
            oe_enable   <= 1'b0;
            oe_disable  <= 1'b0;
        end else begin
            state       <= state_nxt;
            col_addr    <= col_nxt;
            load_row    <= load_nxt;
            row_addr    <= row_nxt;
            sclk        <= (state_nxt == SHIFT_HI);
            delay_start <= (state_nxt == UNBLANK);
            latch_set   <= (state_nxt == LATCH_ON);
            latch_clr   <= (state_nxt == LATCH_OFF);
            oe_enable   <= (state_nxt == UNBLANK);
            oe_disable  <= (state_nxt == BLANK) || (state_nxt == STOP);
        end
    end

    // These two mark the exact cycle their input condition is seen
    assign pix_shift  = (state == SHIFT_LO) && pix_valid;
    assign frame_done = (state == WAIT) && delay_done && last_row;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_led_scan_sequencer.sv
// Directed bench for led_scan_sequencer (COLS=4, ROW_BITS=2) with an event scoreboard.
module tb_led_scan_sequencer;

    localparam int COLS     = 4;
    localparam int ROW_BITS = 2;
    localparam int ROWS     = 4;
    localparam int CW       = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;
    logic pix_valid = 1'b0;
    logic delay_done = 1'b0;
    logic [CW-1:0]       col_addr;
    logic [ROW_BITS-1:0] load_row;
    logic [ROW_BITS-1:0] row_addr;
    logic sclk, pix_shift, delay_start, latch_set, latch_clr;
    logic oe_enable, oe_disable, busy, frame_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_unblank = -1;
    int period = -1;
    bit oe_off = 1'b0;
    logic [ROW_BITS-1:0] prev_row = '0;
    logic [15:0] exp_q[$];

    led_scan_sequencer #(.COLS(COLS), .ROW_BITS(ROW_BITS)) dut (
        .clk(clk), .rst(rst), .enable(enable), .pix_valid(pix_valid),
        .delay_done(delay_done), .col_addr(col_addr), .load_row(load_row),
        .row_addr(row_addr), .sclk(sclk), .pix_shift(pix_shift),
        .delay_start(delay_start), .latch_set(latch_set), .latch_clr(latch_clr),
        .oe_enable(oe_enable), .oe_disable(oe_disable), .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mk(int kind, logic [7:0] val);
        return {8'(kind), val};
    endfunction

    task automatic got(logic [15:0] ev);
        if (exp_q.size() == 0) check("sb_unexpected_event", 32'(ev), 32'h0);
        else check("sb_event", 32'(ev), 32'(exp_q.pop_front()));
    endtask

    // Event monitor and per-cycle invariants, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            check("latch_excl", 32'(latch_set & latch_clr), 32'h0);
            check("oe_excl", 32'(oe_enable & oe_disable), 32'h0);
            if (latch_set | latch_clr) check("latch_while_blank", 32'(oe_off), 32'h1);
            if (row_addr !== prev_row) check("row_addr_while_blank", 32'(oe_off), 32'h1);
            if (pix_shift) got(mk(1, 8'(col_addr)));
            if (sclk) got(mk(2, 8'(col_addr)));
            if (oe_disable) got(mk(3, 8'h0));
            if (latch_set) got(mk(4, 8'h0));
            if (latch_clr) got(mk(5, 8'h0));
            if (oe_enable | delay_start) got(mk(6, 8'({oe_enable, delay_start, row_addr})));
            if (frame_done) got(mk(7, 8'(load_row)));
            if (oe_disable) oe_off = 1'b1;
            if (oe_enable) begin
                oe_off = 1'b0;
                if (last_unblank >= 0) period = cyc - last_unblank;
                last_unblank = cyc;
            end
            prev_row = row_addr;
        end
    end

    task automatic push_row(int row, bit frame, bit stop, bit partial);
        for (int c = 0; c < COLS; c++) begin
            exp_q.push_back(mk(1, 8'(c)));
            exp_q.push_back(mk(2, 8'(c)));
        end
        exp_q.push_back(mk(3, 8'h0));
        exp_q.push_back(mk(4, 8'h0));
        if (!partial) begin
            exp_q.push_back(mk(5, 8'h0));
            exp_q.push_back(mk(6, 8'({2'b11, 2'(row)})));
            if (frame) exp_q.push_back(mk(7, 8'(ROWS - 1)));
            if (stop) exp_q.push_back(mk(3, 8'h0));
        end
    endtask

    function automatic logic probe(int which);
        case (which)
            0:       return sclk && (col_addr == 2'd1);
            1:       return oe_enable;
            default: return latch_set;
        endcase
    endfunction

    task automatic wait_sig(int which, int budget);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!probe(which) && n < budget);
        if (!probe(which)) check($sformatf("timeout_wait_%0d", which), 32'(probe(which)), 32'h1);
    endtask

    task automatic run_row(int row, bit frame, bit stall, bit drop, bit last);
        push_row(row, frame, last, 1'b0);
        if (stall || drop) begin
            wait_sig(0, 50);
            if (drop) enable = 1'b0;
            if (stall) begin
                pix_valid = 1'b0;
                repeat (5) begin
                    @(posedge clk);
                    #1;
                    check("stall_sclk", 32'(sclk), 32'h0);
                    check("stall_col", 32'(col_addr), 32'h2);
                    check("stall_pix_shift", 32'(pix_shift), 32'h0);
                end
                @(posedge clk);
                #1 pix_valid = 1'b1;
            end
        end
        wait_sig(1, 100);
        repeat (10) @(posedge clk);
        #1;
        delay_done = 1'b1;
        enable = !last;
        @(posedge clk);
        #1 delay_done = 1'b0;
    endtask

    task automatic check_reset_state(string tag);
        check({tag, "_pulses"}, 32'({sclk, pix_shift, delay_start, latch_set, latch_clr,
                                     oe_enable, oe_disable, busy, frame_done}), 32'h0);
        check({tag, "_col"}, 32'(col_addr), 32'h0);
        check({tag, "_load_row"}, 32'(load_row), 32'h0);
        check({tag, "_row_addr"}, 32'(row_addr), 32'h0);
    endtask

    initial begin
        #12;
        check_reset_state("reset");
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 32'h0);

        // Full frame with a pixel stall in row 2
        pix_valid = 1'b1;
        enable = 1'b1;
        run_row(0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_row(1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_row(2, 1'b0, 1'b1, 1'b0, 1'b0);
        run_row(3, 1'b1, 1'b0, 1'b0, 1'b0);
        check("frame_wrap_load_row", 32'(load_row), 32'h0);
        check("frame_row_addr", 32'(row_addr), 32'h3);
        check("row_period", 32'(period), 32'(2 * COLS + 5 + 10));

        // enable drops mid-shift of row 1: row completes, then stop
        run_row(0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_row(1, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("stop_busy", 32'(busy), 32'h0);
        check("stop_load_row", 32'(load_row), 32'h2);
        check("stop_row_addr", 32'(row_addr), 32'h1);
        check("stop_drained", 32'(exp_q.size()), 32'h0);

        // Resume at row 2, then reset asynchronously during LATCH_ON
        enable = 1'b1;
        push_row(2, 1'b0, 1'b0, 1'b1);
        wait_sig(2, 100);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check_reset_state("async_reset");
        check("async_reset_drained", 32'(exp_q.size()), 32'h0);
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("held_reset");
        oe_off = 1'b0;
        prev_row = '0;
        last_unblank = -1;
        rst = 1'b1;
        @(posedge clk);
        #1 enable = 1'b1;
        run_row(0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_row(1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("restart_busy", 32'(busy), 32'h0);
        check("restart_load_row", 32'(load_row), 32'h2);
        check("final_drained", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_scan_sequencer.md
LED_SCAN_SEQUENCER -- requirements
Module: led_scan_sequencer

Interface
REQ-001 SHALL have parameter COLS, default 64, meaning pixels shifted per row (power of two, >=2).
REQ-002 SHALL have parameter ROW_BITS, default 4, meaning panel row-address width; ROWS = 2**ROW_BITS.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  in  1  level; 1 = run scanning.
REQ-006 SHALL have port pix_valid  in  1  framebuffer data valid for {load_row, col_addr}.
REQ-007 SHALL have port delay_done  in  1  display-delay complete, from the timing controller.
REQ-008 SHALL have port col_addr  out  $clog2(COLS)  column being loaded.
REQ-009 SHALL have port load_row  out  ROW_BITS  row whose data is being shifted.
REQ-010 SHALL have port row_addr  out  ROW_BITS  row address driven to the panel.
REQ-011 SHALL have port sclk  out  1  panel shift clock.
REQ-012 SHALL have port pix_shift  out  1  strobe that captures framebuffer data onto the panel data pins.
REQ-013 SHALL have ports delay_start, latch_set, latch_clr, oe_enable, oe_disable  out  1 each  single-cycle command pulses to the timing controller.
REQ-014 SHALL have port busy  out  1  state != IDLE.
REQ-015 SHALL have port frame_done  out  1  single-cycle pulse when the last row's display period ends.

Function
REQ-016 SHALL implement the states IDLE, SHIFT_LO, SHIFT_HI, BLANK, LATCH_ON, LATCH_OFF, ADDR, UNBLANK, WAIT and STOP, with registered outputs.
REQ-017 IDLE: all pulses 0, sclk 0; enable=1 -> SHIFT_LO with col_addr=0.
REQ-018 SHIFT_LO: sclk=0; pix_valid=0 -> stay (unbounded stall); pix_valid=1 -> pix_shift=1 for exactly that cycle, next SHIFT_HI.
REQ-019 SHIFT_HI: sclk=1 for one cycle; col_addr<COLS-1 -> col_addr+1, SHIFT_LO; col_addr==COLS-1 -> col_addr=0, BLANK.
REQ-020 BLANK: oe_disable=1 for one cycle -> LATCH_ON.
REQ-021 LATCH_ON: latch_set=1 -> LATCH_OFF; LATCH_OFF: latch_clr=1 -> ADDR.
REQ-022 ADDR: row_addr <= load_row, no pulses -> UNBLANK.
REQ-023 UNBLANK: oe_enable=1 and delay_start=1 in the same cycle -> WAIT.
REQ-024 WAIT: hold until delay_done=1; then load_row <= load_row+1 (wraps ROWS-1 -> 0); next SHIFT_LO if enable=1, else STOP.
REQ-025 frame_done SHALL pulse in the WAIT-exit cycle when load_row==ROWS-1.
REQ-026 STOP: oe_disable=1 for one cycle -> IDLE; load_row keeps its value, so a restart resumes at the next row.
REQ-027 enable SHALL be sampled only in IDLE and at WAIT exit; deassertion mid-row completes that row, including latch and display.
REQ-028 At most one of latch_set/latch_clr and at most one of oe_enable/oe_disable SHALL be high in any cycle.
REQ-029 row_addr SHALL change only in ADDR, i.e. only while OE is disabled.
REQ-030 Per-row cycle count with pix_valid tied high = 2*COLS + 5 + D, where D = cycles spent in WAIT.

Reset
REQ-031 rst=0 SHALL immediately force state=IDLE, col_addr=0, load_row=0, row_addr=0, and all outputs 0, independent of clk.
REQ-032 Reset asserted mid-operation SHALL abort without emitting any further pulse; after release, enable=1 restarts at row 0, col 0.

Verification
REQ-033 COLS=4, ROW_BITS=2, pix_valid=1, enable rises -> 4 sclk high pulses on alternate cycles, col_addr 0,1,2,3, then oe_disable, latch_set, latch_clr on 3 consecutive cycles, row_addr=0, then oe_enable+delay_start.
REQ-034 pix_valid held 0 for 5 cycles at col 2 -> sclk stays 0, col_addr stays 2, no pix_shift; resumes on pix_valid=1.
REQ-035 delay_done after 10 WAIT cycles across 4 rows -> row_addr sequence 0,1,2,3; frame_done pulses once, at row 3 WAIT exit; load_row wraps to 0.
REQ-036 enable drops during SHIFT of row 1 -> row 1 completes latch and display, then a single oe_disable pulse, IDLE, busy=0; re-enable -> load_row=2.
REQ-037 rst=0 asynchronously in LATCH_ON -> all outputs 0 before the next clk edge; no latch_clr is issued; restart begins at row 0.
REQ-038 Every cycle: assert REQ-028 and REQ-029 hold, and latch is high only between an oe_disable and the following oe_enable.
